// File: rtl/top_main_core.sv
// Single-cycle datapath core: data memory (m0), register file (r0) and combinational ALU (a0).
// Optional feature macro: TOP_MAIN_R0_ZERO_EN hardwires register 0 to zero.

module top_main_core_mem #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [MEM_AW-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [MEM_AW-1:0] mon_addr_i,
    output logic [DATA_W-1:0] mon_data_o
);
    localparam int DEPTH = 1 << MEM_AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mon_data_q;

    // Every word must clear on reset, so the array is kept in flops.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (we_i && (waddr_i == MEM_AW'(gi))) begin
                mem_q[gi] <= wdata_i;
            end
        end
    end

    // Readback samples the pre-write contents of this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mon_data_q <= '0;
        end else begin
            mon_data_q <= mem_q[mon_addr_i];
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign mon_data_o = mon_data_q;
endmodule

module top_main_core_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    input  logic [REG_AW-1:0] raddr_c_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] rdata_c_o
);
    localparam int NREGS = 1 << REG_AW;
`ifdef TOP_MAIN_R0_ZERO_EN
    localparam bit R0_HARDWIRED = 1'b1;
`else
    localparam bit R0_HARDWIRED = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [NREGS];

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        localparam bit WRITABLE = !(R0_HARDWIRED && (gi == 0));
        always_ff @(posedge clk) begin
            if (rst) begin
                regs_q[gi] <= '0;
            end else if (WRITABLE && we_i && (waddr_i == REG_AW'(gi))) begin
                regs_q[gi] <= wdata_i;
            end
        end
    end

    // With register 0 hardwired it never leaves its reset value, so plain indexing reads 0.
    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
    assign rdata_c_o = regs_q[raddr_c_i];
endmodule

module top_main_core_alu #(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);
    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            4'b0101: result_o = a_i + b_i;
            4'b0110: result_o = a_i - b_i;
            4'b0111: result_o = a_i & b_i;
            4'b1000: result_o = a_i | b_i;
            4'b1001: result_o = a_i ^ b_i;
            4'b1010: result_o = a_i << shamt;
            4'b1011: result_o = a_i >> shamt;
            4'b1100: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
    end
endmodule

module top_main_core #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 4,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        opcode,
    input  logic [MEM_AW-1:0] read_address,
    input  logic [MEM_AW-1:0] write_address,
    input  logic [REG_AW-1:0] read_address_reg,
    input  logic [REG_AW-1:0] write_address_reg,
    input  logic [REG_AW-1:0] reg1,
    input  logic [REG_AW-1:0] reg2,
    input  logic [MEM_AW-1:0] address_mem,
    input  logic [REG_AW-1:0] address_alu,
    output logic [MEM_AW-1:0] address_to_mem,
    output logic [DATA_W-1:0] data_out_mem,
    output logic              zero
);
    typedef enum logic [3:0] {
        OP_NOP        = 4'b0000,
        OP_STORE_IMM  = 4'b0001,
        OP_LOAD_IMM   = 4'b0010,
        OP_MEM_TO_REG = 4'b0011,
        OP_REG_TO_MEM = 4'b0100
    } opcode_e;

    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              reg_we;
    logic [REG_AW-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] reg_src;
    logic [DATA_W-1:0] alu_result;
    logic              is_alu;

    logic [MEM_AW-1:0] addr_to_mem_q, addr_to_mem_d;
    logic              zero_q, zero_d;

    top_main_core_mem #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) m0 (
        .clk        (clk),
        .rst        (rst),
        .we_i       (mem_we),
        .waddr_i    (write_address),
        .wdata_i    (mem_wdata),
        .raddr_i    (read_address),
        .rdata_o    (mem_rdata),
        .mon_addr_i (address_mem),
        .mon_data_o (data_out_mem)
    );

    top_main_core_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) r0 (
        .clk       (clk),
        .rst       (rst),
        .we_i      (reg_we),
        .waddr_i   (reg_waddr),
        .wdata_i   (reg_wdata),
        .raddr_a_i (reg1),
        .raddr_b_i (reg2),
        .raddr_c_i (read_address_reg),
        .rdata_a_o (op_a),
        .rdata_b_o (op_b),
        .rdata_c_o (reg_src)
    );

    top_main_core_alu #(.DATA_W(DATA_W)) a0 (
        .op_i     (opcode),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (alu_result)
    );

    assign is_alu = (opcode >= 4'b0101) && (opcode <= 4'b1100);

    always_comb begin
        mem_we        = 1'b0;
        mem_wdata     = data_in;
        reg_we        = 1'b0;
        reg_waddr     = write_address_reg;
        reg_wdata     = data_in;
        addr_to_mem_d = addr_to_mem_q;
        zero_d        = zero_q;
        case (opcode)
            OP_STORE_IMM: begin
                mem_we        = 1'b1;
                addr_to_mem_d = write_address;
            end
            OP_LOAD_IMM: begin
                reg_we = 1'b1;
            end
            OP_MEM_TO_REG: begin
                reg_we        = 1'b1;
                reg_wdata     = mem_rdata;
                addr_to_mem_d = read_address;
            end
            OP_REG_TO_MEM: begin
                mem_we        = 1'b1;
                mem_wdata     = reg_src;
                addr_to_mem_d = write_address;
            end
            default: begin
                // Operands are read combinationally, so a destination equal to reg1/reg2 uses the old value.
                if (is_alu) begin
                    reg_we    = 1'b1;
                    reg_waddr = address_alu;
                    reg_wdata = alu_result;
                    zero_d    = (alu_result == '0);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_to_mem_q <= '0;
            zero_q        <= 1'b0;
        end else begin
            addr_to_mem_q <= addr_to_mem_d;
            zero_q        <= zero_d;
        end
    end

    assign address_to_mem = addr_to_mem_q;
    assign zero           = zero_q;
endmodule

// File: tb/tb_top_main_core.sv
// Directed self-checking bench for top_main_core; honours TOP_MAIN_R0_ZERO_EN when defined.

module tb_top_main_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [3:0]  opcode;
    logic [3:0]  read_address;
    logic [3:0]  write_address;
    logic [2:0]  read_address_reg;
    logic [2:0]  write_address_reg;
    logic [2:0]  reg1;
    logic [2:0]  reg2;
    logic [3:0]  address_mem;
    logic [2:0]  address_alu;
    logic [3:0]  address_to_mem;
    logic [31:0] data_out_mem;
    logic        zero;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] NOP = 4'd0, STI = 4'd1, LDI = 4'd2, M2R = 4'd3, R2M = 4'd4,
                           ADD = 4'd5, SUB = 4'd6, AND_ = 4'd7, OR_ = 4'd8, XOR_ = 4'd9,
                           SLL = 4'd10, SRL = 4'd11, SLT = 4'd12;

    top_main_core dut (
        .clk               (clk),
        .rst               (rst),
        .data_in           (data_in),
        .opcode            (opcode),
        .read_address      (read_address),
        .write_address     (write_address),
        .read_address_reg  (read_address_reg),
        .write_address_reg (write_address_reg),
        .reg1              (reg1),
        .reg2              (reg2),
        .address_mem       (address_mem),
        .address_alu       (address_alu),
        .address_to_mem    (address_to_mem),
        .data_out_mem      (data_out_mem),
        .zero              (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        opcode = NOP;
        rst    = 1'b0;
    endtask

    task automatic store_imm(input logic [3:0] a, input logic [31:0] v);
        opcode = STI; write_address = a; data_in = v;
        step();
    endtask

    task automatic load_imm(input logic [2:0] r, input logic [31:0] v);
        opcode = LDI; write_address_reg = r; data_in = v;
        step();
    endtask

    task automatic alu(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
        opcode = op; reg1 = a; reg2 = b; address_alu = d;
        step();
    endtask

    initial begin
        rst = 1'b1; opcode = NOP; data_in = '0; read_address = '0; write_address = '0;
        read_address_reg = '0; write_address_reg = '0; reg1 = '0; reg2 = '0;
        address_mem = '0; address_alu = '0;
        #1;
        rst = 1'b1;
        step();

        // Reset state
        check("rst_dout", data_out_mem, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h0);
        check("rst_atm", {28'b0, address_to_mem}, 32'h0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_reg%0d", i), dut.r0.regs_q[i], 32'h0);
        for (int i = 0; i < 16; i++) check($sformatf("rst_mem%0d", i), dut.m0.mem_q[i], 32'h0);

        // Store and readback, including the same-cycle old-word case
        address_mem = 4'd5;
        store_imm(4'd5, 32'hDEADBEEF);
        check("st_dout_old", data_out_mem, 32'h0);
        check("st_atm", {28'b0, address_to_mem}, 32'd5);
        step();
        check("st_dout_new", data_out_mem, 32'hDEADBEEF);

        // Register ALU
        load_imm(3'd1, 32'd7);
        load_imm(3'd2, 32'd7);
        alu(SUB, 3'd1, 3'd2, 3'd3);
        check("sub_r3", dut.r0.regs_q[3], 32'h0);
        check("sub_zero", {31'b0, zero}, 32'h1);
        alu(ADD, 3'd1, 3'd2, 3'd4);
        check("add_r4", dut.r0.regs_q[4], 32'd14);
        check("add_zero", {31'b0, zero}, 32'h0);
        alu(ADD, 3'd1, 3'd1, 3'd1);
        check("hazard_r1", dut.r0.regs_q[1], 32'd14);
        load_imm(3'd6, 32'd1);
        check("ldi_zero_hold", {31'b0, zero}, 32'h0);

        // Memory <-> register round trip
        store_imm(4'd2, 32'h1234);
        check("rt_atm0", {28'b0, address_to_mem}, 32'd2);
        opcode = M2R; read_address = 4'd2; write_address_reg = 3'd5;
        step();
        check("rt_atm1", {28'b0, address_to_mem}, 32'd2);
        check("rt_r5", dut.r0.regs_q[5], 32'h1234);
        opcode = R2M; read_address_reg = 3'd5; write_address = 4'd9;
        step();
        check("rt_atm2", {28'b0, address_to_mem}, 32'd9);
        check("rt_mem9", dut.m0.mem_q[9], 32'h1234);
        step();
        check("nop_atm_hold", {28'b0, address_to_mem}, 32'd9);

        // Signed compare, shifts, logic ops
        load_imm(3'd1, 32'hFFFFFFFF);
        load_imm(3'd2, 32'd1);
        alu(SLT, 3'd1, 3'd2, 3'd6);
        check("slt_r6", dut.r0.regs_q[6], 32'd1);
        alu(SLT, 3'd2, 3'd1, 3'd6);
        check("slt_rev_r6", dut.r0.regs_q[6], 32'd0);
        check("slt_rev_zero", {31'b0, zero}, 32'h1);
        alu(SRL, 3'd1, 3'd2, 3'd7);
        check("srl_r7", dut.r0.regs_q[7], 32'h7FFFFFFF);
        load_imm(3'd2, 32'd36);
        alu(SLL, 3'd1, 3'd2, 3'd6);
        check("sll_r6", dut.r0.regs_q[6], 32'hFFFFFFF0);
        alu(AND_, 3'd1, 3'd2, 3'd3);
        check("and_r3", dut.r0.regs_q[3], 32'h24);
        alu(OR_, 3'd1, 3'd2, 3'd3);
        check("or_r3", dut.r0.regs_q[3], 32'hFFFFFFFF);
        alu(XOR_, 3'd1, 3'd2, 3'd3);
        check("xor_r3", dut.r0.regs_q[3], 32'hFFFFFFDB);
        alu(4'b1110, 3'd1, 3'd2, 3'd3);
        check("op14_r3", dut.r0.regs_q[3], 32'hFFFFFFDB);
        check("op14_zero", {31'b0, zero}, 32'h0);

        // Register 0 behaviour (macro-dependent)
        load_imm(3'd0, 32'd5);
        alu(ADD, 3'd0, 3'd0, 3'd3);
`ifdef TOP_MAIN_R0_ZERO_EN
        check("r0_add_r3", dut.r0.regs_q[3], 32'd0);
        check("r0_add_zero", {31'b0, zero}, 32'h1);
`else
        check("r0_add_r3", dut.r0.regs_q[3], 32'd10);
        check("r0_add_zero", {31'b0, zero}, 32'h0);
`endif

        // Reset overriding a simultaneous store
        rst = 1'b1; opcode = STI; write_address = 4'd12; data_in = 32'hAAAA5555;
        step();
        check("rst_mid_mem12", dut.m0.mem_q[12], 32'h0);
        check("rst_mid_mem5", dut.m0.mem_q[5], 32'h0);
        check("rst_mid_r4", dut.r0.regs_q[4], 32'h0);
        check("rst_mid_atm", {28'b0, address_to_mem}, 32'h0);
        address_mem = 4'd9;
        step();
        check("rst_mid_dout", data_out_mem, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
